jam_ctrl: RTL and testbench

JAM_CTRL -- requirements
Module: jam_ctrl

---
 rtl/jam_ctrl.sv | 146 ++++++++++++++
 tb/tb_jam_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_ctrl.sv
// jam_ctrl: loads a 64x7 cost table, serves costs to an assignment engine and captures its result.
// Define JAM_CTRL_CYCLE_CNT_EN to add the RUN-cycle counter reported on res_cyc.
module jam_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_data,
  output logic        jam_rst,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  input  logic        jam_valid,
  input  logic [9:0]  jam_min,
  input  logic [3:0]  jam_cnt,
  output logic        res_valid,
  output logic [9:0]  res_min,
  output logic [3:0]  res_cnt,
`ifdef JAM_CTRL_CYCLE_CNT_EN
  output logic [17:0] res_cyc,
`endif
  input  logic        res_ack
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t     state_r;
  logic [5:0] idx_r;
  logic [6:0] table_r [0:63];
  logic       cfg_ready_r;
  logic       jam_rst_r;
  logic       res_valid_r;
  logic [9:0] res_min_r;
  logic [3:0] res_cnt_r;
  logic       load_hs_s;
  logic [6:0] cost_s;

  assign load_hs_s = (state_r == LOAD) && cfg_valid;

  // Cost table storage; deliberately left out of reset so it persists across runs.
  always_ff @(posedge CLK) begin
    if (load_hs_s) begin
      table_r[idx_r] <= cfg_data;
    end
  end

  // Zero-latency cost lookup, gated to zero outside RUN.
  always_comb begin
    cost_s = 7'd0;
    if (state_r == RUN) begin
      cost_s = table_r[{W, J}];
    end else begin
      cost_s = 7'd0;
    end
  end

  // Control FSM with registered handshake, engine-reset and result outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= LOAD;
      idx_r       <= 6'd0;
      cfg_ready_r <= 1'b1;
      jam_rst_r   <= 1'b1;
      res_valid_r <= 1'b0;
      res_min_r   <= 10'd0;
      res_cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        LOAD: begin
          if (cfg_valid) begin
            idx_r <= idx_r + 6'd1;
            if (idx_r == 6'd63) begin
              state_r     <= START;
              cfg_ready_r <= 1'b0;
            end
          end
        end
        START: begin
          state_r   <= RUN;
          jam_rst_r <= 1'b0;
        end
        RUN: begin
          if (jam_valid) begin
            state_r     <= HOLD;
            res_min_r   <= jam_min;
            res_cnt_r   <= jam_cnt;
            res_valid_r <= 1'b1;
            jam_rst_r   <= 1'b1;
          end
        end
        HOLD: begin
          if (res_ack) begin
            state_r     <= LOAD;
            idx_r       <= 6'd0;
            res_valid_r <= 1'b0;
            cfg_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= LOAD;
          idx_r       <= 6'd0;
          cfg_ready_r <= 1'b1;
          jam_rst_r   <= 1'b1;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef JAM_CTRL_CYCLE_CNT_EN
  logic [17:0] cyc_r;
  logic [17:0] res_cyc_r;

  // RUN-cycle counter, cleared in START and saturating; sampled together with the result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc_r     <= 18'd0;
      res_cyc_r <= 18'd0;
    end else begin
      if (state_r == START) begin
        cyc_r <= 18'd0;
      end else if ((state_r == RUN) && (cyc_r != 18'h3FFFF)) begin
        cyc_r <= cyc_r + 18'd1;
      end
      if ((state_r == RUN) && jam_valid) begin
        res_cyc_r <= cyc_r;
      end
    end
  end

  assign res_cyc = res_cyc_r;
`endif

  assign cfg_ready = cfg_ready_r;
  assign jam_rst   = jam_rst_r;
  assign res_valid = res_valid_r;
  assign res_min   = res_min_r;
  assign res_cnt   = res_cnt_r;
  assign Cost      = cost_s;

endmodule

// File: tb/tb_jam_ctrl.sv
// Self-checking bench for jam_ctrl: cost vector table, result scoreboard and reset/handshake sequences.
`timescale 1ns/1ps
module tb_jam_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [6:0]  cfg_data;
  logic        jam_rst;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic        jam_valid;
  logic [9:0]  jam_min;
  logic [3:0]  jam_cnt;
  logic        res_valid;
  logic [9:0]  res_min;
  logic [3:0]  res_cnt;
  logic        res_ack;
`ifdef JAM_CTRL_CYCLE_CNT_EN
  logic [17:0] res_cyc;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] w;
    logic [2:0] j;
    logic [6:0] exp_a;
    logic [6:0] exp_b;
  } vec_t;
  vec_t vecs [8];

  typedef struct {
    logic [9:0] min;
    logic [3:0] cnt;
  } res_t;
  res_t sb [$];

  always #5 CLK = ~CLK;

  jam_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .jam_rst   (jam_rst),
    .W         (W),
    .J         (J),
    .Cost      (Cost),
    .jam_valid (jam_valid),
    .jam_min   (jam_min),
    .jam_cnt   (jam_cnt),
    .res_valid (res_valid),
    .res_min   (res_min),
    .res_cnt   (res_cnt),
`ifdef JAM_CTRL_CYCLE_CNT_EN
    .res_cyc   (res_cyc),
`endif
    .res_ack   (res_ack)
  );

  // pattern 0: k % 128, pattern 1: (3k + 5) % 128
  function automatic logic [6:0] pat(input int sel, input int k);
    int v;
    v = (sel == 0) ? (k % 128) : ((k * 3 + 5) % 128);
    return v[6:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Streams words until stop_at handshakes; gaps=1 drops cfg_valid every third cycle.
  task automatic load_words(input int sel, input int gaps, input int stop_at);
    int accepted;
    int bad;
    accepted = 0;
    bad = 0;
    for (int c = 0; c < 400 && accepted < stop_at; c++) begin
      cfg_valid = (gaps == 0) ? 1'b1 : ((c % 3) != 1);
      cfg_data  = pat(sel, accepted);
      if (cfg_ready !== 1'b1 || jam_rst !== 1'b1) bad++;
      if (cfg_valid && cfg_ready) accepted++;
      tick();
    end
    cfg_valid = 1'b0;
    check("load_ready_held", bad, 0);
    check("load_accepted", accepted, stop_at);
  endtask

  task automatic enter_run(input int sel, input int gaps);
    load_words(sel, gaps, 64);
    check("start_cfg_ready", cfg_ready, 1'b0);
    check("start_jam_rst", jam_rst, 1'b1);
    check("start_cost", Cost, 7'd0);
    tick();
    check("run_jam_rst", jam_rst, 1'b0);
    check("run_cfg_ready", cfg_ready, 1'b0);
  endtask

  task automatic run_vectors(input int sel);
    for (int i = 0; i < 8; i++) begin
      W = vecs[i].w;
      J = vecs[i].j;
      #1;
      check($sformatf("cost_w%0d_j%0d", vecs[i].w, vecs[i].j), Cost,
            (sel == 0) ? vecs[i].exp_a : vecs[i].exp_b);
      tick();
    end
  endtask

  task automatic give_result(input logic [9:0] mn, input logic [3:0] cn);
    res_t e;
    res_t got;
    int waited;
    jam_min   = mn;
    jam_cnt   = cn;
    jam_valid = 1'b1;
    e.min = mn;
    e.cnt = cn;
    sb.push_back(e);
    tick();
    jam_valid = 1'b0;
    check("res_valid_next", res_valid, 1'b1);
    waited = 0;
    while (res_valid !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    if (res_valid === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      check("res_min", res_min, got.min);
      check("res_cnt", res_cnt, got.cnt);
    end else begin
      sb.delete();
      check("res_timeout", 32'd1, 32'd0);
    end
  endtask

  task automatic ack_result();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check("ack_res_valid", res_valid, 1'b0);
    check("ack_cfg_ready", cfg_ready, 1'b1);
    check("ack_jam_rst", jam_rst, 1'b1);
    check("load_cost_zero", Cost, 7'd0);
  endtask

  initial begin
    vecs[0] = '{3'd3, 3'd5, 7'd29, 7'd92};
    vecs[1] = '{3'd0, 3'd0, 7'd0,  7'd5};
    vecs[2] = '{3'd7, 3'd7, 7'd63, 7'd66};
    vecs[3] = '{3'd1, 3'd0, 7'd8,  7'd29};
    vecs[4] = '{3'd5, 3'd2, 7'd42, 7'd3};
    vecs[5] = '{3'd2, 3'd6, 7'd22, 7'd71};
    vecs[6] = '{3'd6, 3'd1, 7'd49, 7'd24};
    vecs[7] = '{3'd4, 3'd7, 7'd39, 7'd122};

    RST = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 7'd0;
    W = 3'd3;
    J = 3'd5;
    jam_valid = 1'b0;
    jam_min   = 10'd0;
    jam_cnt   = 4'd0;
    res_ack   = 1'b0;
    #2;
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_jam_rst", jam_rst, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_min", res_min, 10'd0);
    check("rst_res_cnt", res_cnt, 4'd0);
    check("rst_cost", Cost, 7'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Gapless load of k%128, lookups, then result capture and HOLD behaviour.
    enter_run(0, 0);
    run_vectors(0);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check("ack_in_run_jam_rst", jam_rst, 1'b0);
    check("ack_in_run_res_valid", res_valid, 1'b0);
    give_result(10'd523, 4'd2);
    W = 3'd3;
    J = 3'd5;
    #1;
    check("hold_jam_rst", jam_rst, 1'b1);
    check("hold_cfg_ready", cfg_ready, 1'b0);
    check("hold_cost", Cost, 7'd0);
    cfg_valid = 1'b1;
    cfg_data  = 7'h7F;
    jam_valid = 1'b1;
    jam_min   = 10'd1;
    jam_cnt   = 4'd1;
    repeat (3) tick();
    cfg_valid = 1'b0;
    jam_valid = 1'b0;
    check("hold_res_valid", res_valid, 1'b1);
    check("hold_res_min", res_min, 10'd523);
    check("hold_res_cnt", res_cnt, 4'd2);
    ack_result();

    // Gapped load with a second pattern; START must follow the 64th handshake exactly.
    enter_run(1, 1);
    run_vectors(1);
    give_result(10'd1023, 4'd15);
    ack_result();

    // Abandon a load at idx=40 with an asynchronous reset, then reload fully.
    load_words(0, 0, 40);
    #3;
    RST = 1'b1;
    #1;
    check("midload_rst_cfg_ready", cfg_ready, 1'b1);
    check("midload_rst_jam_rst", jam_rst, 1'b1);
    #2;
    RST = 1'b0;
    tick();
    enter_run(0, 0);
`ifdef JAM_CTRL_CYCLE_CNT_EN
    repeat (1000) tick();
    give_result(10'd100, 4'd5);
    check("res_cyc_1000", res_cyc, 18'd1000);
`else
    run_vectors(0);
    give_result(10'd100, 4'd5);
`endif
    ack_result();

    // Reset in the middle of RUN must drop the engine back into reset immediately.
    enter_run(1, 1);
    run_vectors(1);
    #3;
    RST = 1'b1;
    #1;
    check("midrun_rst_jam_rst", jam_rst, 1'b1);
    check("midrun_rst_cfg_ready", cfg_ready, 1'b1);
    check("midrun_rst_cost", Cost, 7'd0);
    check("midrun_rst_res_valid", res_valid, 1'b0);
    #2;
    RST = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
